// File: rtl/mips_single_cycle_core.sv
// Single-cycle 32-bit MIPS subset core with internal instruction/data memories.
// Optional board-bring-up LED outputs are enabled by defining TEST_PROB_EN.
module mips_single_cycle_core #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MEM_SIZE  = 256
) (
    input  logic        clk,
    input  logic        reset,
`ifdef TEST_PROB_EN
    output logic        led_synth,
    output logic        led_prob_3,
    output logic        led_prob_2,
    output logic        led_prob_1,
    output logic        led_prob_0,
`endif
    output logic [31:0] pc
);
    localparam int unsigned AW = $clog2(MEM_SIZE);

    logic [MEM_WIDTH-1:0] imem [MEM_SIZE];
    logic [MEM_WIDTH-1:0] dmem [MEM_SIZE];
    logic [31:0]          regs [32];

    // Data memory cleared at time 0.
    initial begin
        for (int i = 0; i < int'(MEM_SIZE); i++) dmem[i] = '0;
    end

    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] sext, zext, rs_val, rt_val, pc_plus4;
    logic [31:0] alu_res, wr_data, dmem_rdata, next_pc;
    logic [4:0]  wr_addr;
    logic        reg_we, mem_we, is_jump;

    assign instr    = 32'(imem[pc[AW+1:2]]);
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign sext     = {{16{instr[15]}}, instr[15:0]};
    assign zext     = {16'h0000, instr[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign pc_plus4 = pc + 32'd4;

    // Decode and execute; anything unrecognised falls through as a NOP.
    always_comb begin
        alu_res    = 32'd0;
        wr_addr    = rd;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        is_jump    = 1'b0;
        next_pc    = pc_plus4;
        dmem_rdata = 32'd0;
        wr_data    = 32'd0;
        case (op)
            6'h00: begin
                reg_we = 1'b1;
                case (funct)
                    6'h20:   alu_res = rs_val + rt_val;
                    6'h22:   alu_res = rs_val - rt_val;
                    6'h24:   alu_res = rs_val & rt_val;
                    6'h25:   alu_res = rs_val | rt_val;
                    6'h2A:   alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h00:   alu_res = rt_val << shamt;
                    default: reg_we  = 1'b0;
                endcase
            end
            6'h08: begin alu_res = rs_val + sext; wr_addr = rt; reg_we = 1'b1; end
            6'h0C: begin alu_res = rs_val & zext; wr_addr = rt; reg_we = 1'b1; end
            6'h0D: begin alu_res = rs_val | zext; wr_addr = rt; reg_we = 1'b1; end
            6'h23: begin alu_res = rs_val + sext; wr_addr = rt; reg_we = 1'b1; end
            6'h2B: begin alu_res = rs_val + sext; mem_we = 1'b1; end
            6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + (sext << 2);
            6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + (sext << 2);
            6'h02: begin next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}; is_jump = 1'b1; end
            default: ;
        endcase
        dmem_rdata = 32'(dmem[alu_res[AW+1:2]]);
        wr_data    = (op == 6'h23) ? dmem_rdata : alu_res;
    end

    // Architectural state; memory writes only happen outside reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (reg_we && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
            if (mem_we) dmem[alu_res[AW+1:2]] <= MEM_WIDTH'(rt_val);
        end
    end

`ifdef TEST_PROB_EN
    assign led_prob_0 = |dmem[0];
    assign led_prob_1 = |dmem[1];
    assign led_prob_2 = |dmem[2];
    assign led_prob_3 = |dmem[3];

    // Latches once the program reaches a jump-to-self halt loop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          led_synth <= 1'b0;
        else if (is_jump && next_pc == pc)   led_synth <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Scoreboard bench for mips_single_cycle_core: ISA-level reference model,
// directed programs plus random programs, checked by a negedge monitor.
module tb_mips_single_cycle_core;
    logic        clk;
    logic        reset;
    logic [31:0] pc;
`ifdef TEST_PROB_EN
    logic led_synth, led_prob_3, led_prob_2, led_prob_1, led_prob_0;
`endif

    mips_single_cycle_core dut (
        .clk   (clk),
        .reset (reset),
`ifdef TEST_PROB_EN
        .led_synth  (led_synth),
        .led_prob_3 (led_prob_3),
        .led_prob_2 (led_prob_2),
        .led_prob_1 (led_prob_1),
        .led_prob_0 (led_prob_0),
`endif
        .pc    (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0][31:0] regs;
        logic [7:0]        dm_idx;
        logic [31:0]       dm_val;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] prog    [256];
    logic [31:0] m_regs  [32];
    logic [31:0] m_dmem  [256];
    logic [31:0] m_pc;
    logic [7:0]  last_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.pc = m_pc;
        for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
        e.dm_idx = last_idx;
        e.dm_val = m_dmem[last_idx];
        sb.push_back(e);
    endtask

    // Instruction-set reference: one architectural step per call.
    task automatic model_step();
        logic [31:0] ins, a, b, simm, npc, wv;
        logic [4:0]  wr;
        logic [7:0]  idx;
        ins  = prog[(m_pc / 4) % 256];
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        simm = 32'($signed(ins[15:0]));
        npc  = m_pc + 4;
        wr   = 5'd0;
        wv   = 32'd0;
        idx  = 8'((a + simm) / 4);
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: begin wr = ins[15:11]; wv = a + b; end
                    6'h22: begin wr = ins[15:11]; wv = a - b; end
                    6'h24: begin wr = ins[15:11]; wv = a & b; end
                    6'h25: begin wr = ins[15:11]; wv = a | b; end
                    6'h2A: begin wr = ins[15:11]; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    6'h00: begin wr = ins[15:11]; wv = b << ins[10:6]; end
                    default: ;
                endcase
            end
            6'h08: begin wr = ins[20:16]; wv = a + simm; end
            6'h0C: begin wr = ins[20:16]; wv = a & 32'(ins[15:0]); end
            6'h0D: begin wr = ins[20:16]; wv = a | 32'(ins[15:0]); end
            6'h23: begin wr = ins[20:16]; wv = m_dmem[idx]; end
            6'h2B: begin m_dmem[idx] = b; last_idx = idx; end
            6'h04: if (a == b) npc = npc + simm * 4;
            6'h05: if (a != b) npc = npc + simm * 4;
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr != 5'd0) m_regs[wr] = wv;
        m_pc = npc;
        push_expected();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  f;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 6))
            0: f = 6'h20;  1: f = 6'h22;  2: f = 6'h24;  3: f = 6'h25;
            4: f = 6'h2A;  5: f = 6'h00;  default: f = 6'h21;
        endcase
        case ($urandom_range(0, 10))
            0:  return {6'h00, rs, rt, rd, sh, f};
            1:  return {6'h08, rs, rt, imm};
            2:  return {6'h0C, rs, rt, imm};
            3:  return {6'h0D, rs, rt, imm};
            4:  return {6'h23, rs, rt, 16'($urandom_range(0, 64))};
            5:  return {6'h2B, rs, rt, 16'($urandom_range(0, 64))};
            6:  return {6'h04, rs, rt, 16'($urandom_range(0, 6)) - 16'd3};
            7:  return {6'h05, rs, rt, 16'($urandom_range(0, 6)) - 16'd3};
            8:  return {6'h02, 26'($urandom_range(0, 19))};
            9:  return {6'h3F, 26'($urandom)};
            default: return {6'h00, rs, rt, rd, sh, f};
        endcase
    endfunction

    // Reset (asynchronously, mid-program), load, hold reset 3 cycles, run.
    task automatic run_program(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'd0);
        for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        repeat (3) begin
            push_expected();
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) begin
            model_step();
            @(posedge clk);
        end
        @(negedge clk);
        #1;
    endtask

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            int   bad;
            e   = sb.pop_front();
            check("pc", pc, e.pc);
            bad = -1;
            for (int r = 0; r < 32; r++)
                if (dut.regs[r] !== e.regs[r] && bad < 0) bad = r;
            n_tests++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL regs: $%0d got %h expected %h (pc exp %h)",
                         bad, dut.regs[bad], e.regs[bad], e.pc);
            end
            check("dmem", 32'(dut.dmem[e.dm_idx]), e.dm_val);
        end
    end

    initial begin
        reset    = 1'b0;
        last_idx = 8'd0;
        for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;
        #1;

`ifdef TEST_PROB_EN
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
        prog[0] = 32'h20010001;
        prog[1] = 32'hAC010000;
        prog[2] = 32'hAC010004;
        prog[3] = 32'hAC010008;
        prog[4] = 32'hAC01000C;
        prog[7] = 32'h08000007;
        run_program(12);
        check("led_prob", 32'({led_prob_3, led_prob_2, led_prob_1, led_prob_0}), 32'hF);
        check("led_synth", 32'(led_synth), 32'd1);
        check("halt_pc", pc, 32'h1C);
`endif

        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
        prog[0]  = 32'h20010005;  // addi $1,$0,5
        prog[1]  = 32'h20020007;  // addi $2,$0,7
        prog[2]  = 32'h00221820;  // add  $3,$1,$2
        prog[3]  = 32'hAC030000;  // sw   $3,0($0)
        prog[4]  = 32'h8C040000;  // lw   $4,0($0)
        prog[5]  = 32'h00842020;  // add  $4,$4,$4 (uses load result)
        prog[6]  = 32'h20000009;  // addi $0,$0,9
        prog[7]  = 32'h10210001;  // beq  $1,$1,+1
        prog[8]  = 32'h20010063;  // skipped
        prog[9]  = 32'h14210001;  // bne  $1,$1 (not taken)
        prog[10] = 32'h00222822;  // sub  $5,$1,$2
        prog[11] = 32'h00A1302A;  // slt  $6,$5,$1
        prog[12] = 32'hFC000000;  // undefined
        prog[13] = 32'h00043880;  // sll  $7,$4,2
        prog[14] = 32'h3088000F;  // andi $8,$4,0xF
        prog[15] = 32'h348900F0;  // ori  $9,$4,0xF0
        prog[16] = 32'h2003FFFF;  // addi $3,$0,-1
        prog[17] = 32'h08000012;  // j 18
        prog[18] = 32'h08000012;  // halt loop
        run_program(24);

        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) prog[i] = 32'd0;
            for (int i = 0; i < 20; i++) prog[i] = rand_instr();
            run_program(40);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
